multi_mode_controller: RTL and testbench
========================================

MULTI_MODE_CONTROLLER -- requirements
Module: multi_mode_controller

Interface
REQ-001 Parameter KEY_WIDTH, default 8: serial key length in bits, legal range 3..32.
REQ-002 Parameter MODE_WIDTH, default 2: mode field width, taken from the key LSBs, legal range 1..KEY_WIDTH-2.
REQ-003 Parameter KEY_ID, default 6'h2B: required value of key bits [KEY_WIDTH-1:MODE_WIDTH].
REQ-004 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent waiting for TransferDone, legal range 1..65535.
REQ-005 Clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Reset  in  1  reset, asynchronous and active-low.
REQ-007 KeyLoad  in  1  qualifies InputKey as a key bit.
REQ-008 InputKey  in  1  serial key bit, MSB first.
REQ-009 ValidCmd  in  1  command strobe.
REQ-010 RW  in  1  command type sampled with ValidCmd: 1 = read, 0 = write.
REQ-011 TransferDone  in  1  transceiver completion.
REQ-012 Busy  out  1  a command is in progress.
REQ-013 Active  out  1  a valid key is loaded.
REQ-014 Mode  out  MODE_WIDTH  mode from the last valid key.
REQ-015 AccessMem  out  1  memory access strobe.
REQ-016 RWMem  out  1  memory direction: 1 = read, 0 = write.
REQ-017 SampleData  out  1  transceiver sample enable.
REQ-018 TransferData  out  1  transceiver send enable.
REQ-019 Timeout  out  1  one-cycle pulse on transfer timeout.
REQ-020 KeyError  out  1  one-cycle pulse on key mismatch.

Function
REQ-021 Key shifting:
- Each cycle with KeyLoad=1 and Busy=0 shifts InputKey into a KEY_WIDTH shift register and increments a bit counter.
- A cycle with KeyLoad=0 before the count completes clears the counter; Active and Mode are unchanged.
REQ-022 Key match: on the edge sampling the KEY_WIDTH-th bit, if the assembled key's upper bits equal KEY_ID:
- Active becomes 1 and Mode takes the assembled key's low MODE_WIDTH bits, both visible the next cycle.
- The counter clears.
REQ-023 Key mismatch: on that same edge, with no match:
- Active becomes 0 and Mode holds its value.
- KeyError pulses for exactly one cycle.
- The counter clears.
REQ-024 KeyLoad while Busy=1 is ignored and holds the counter at 0; a key load in progress when a command starts is discarded.
REQ-025 FSM states: IDLE, READY, RD_MEM, RD_XFER, WR_SAMPLE, WR_MEM.
- Active=0 forces IDLE.
- Active=1 with no command is READY.
REQ-026 In READY, ValidCmd=1 with RW=1 enters RD_MEM and ValidCmd=1 with RW=0 enters WR_SAMPLE. ValidCmd is ignored in every other state and whenever Active=0.
REQ-027 RD_MEM lasts exactly 1 cycle with AccessMem=1, RWMem=1, then goes to RD_XFER.
REQ-028 RD_XFER asserts TransferData=1 until TransferDone=1, then returns to READY.
REQ-029 WR_SAMPLE asserts SampleData=1 until TransferDone=1, then goes to WR_MEM.
REQ-030 WR_MEM lasts exactly 1 cycle with AccessMem=1, RWMem=0, then returns to READY.
REQ-031 Busy=1 in RD_MEM, RD_XFER, WR_SAMPLE and WR_MEM; Busy=0 otherwise. Busy first rises the cycle after ValidCmd is accepted.
REQ-032 Wait counter:
- Clears on entry to RD_XFER or WR_SAMPLE and increments every cycle in those states.
- When it reaches TIMEOUT_CYCLES with TransferDone=0, the FSM returns to READY and Timeout pulses for 1 cycle.
- A timeout in WR_SAMPLE skips WR_MEM, so no memory write occurs.
REQ-033 If TransferDone=1 in the same cycle the count reaches TIMEOUT_CYCLES, TransferDone wins and Timeout stays 0.
REQ-034 TransferDone outside RD_XFER and WR_SAMPLE is ignored.
REQ-035 All outputs are registered, with no combinational path from inputs to outputs.
REQ-036 Counter widths:
- Bit counter is $clog2(KEY_WIDTH+1) bits.
- Wait counter is $clog2(TIMEOUT_CYCLES+1) bits.
- Neither counter wraps.

Reset
REQ-037 Reset=0 immediately, without waiting for a clock edge:
- Forces IDLE.
- Drives every output to 0, with Mode = 0.
- Clears the shift register, bit counter and wait counter.
REQ-038 Reset mid-transfer aborts with no further AccessMem pulse. After release, Active=0 until a new valid key is loaded.
REQ-039 The first rising edge after Reset returns to 1 is a normal functional edge.

Verification
REQ-040 Defaults; KeyLoad=1 for 8 cycles shifting 8'b10101110 -> Active=1 and Mode=2'b10 on the next cycle; KeyError=0.
REQ-041 Active=1; key 8'b11111101 -> Active=0, KeyError high exactly 1 cycle, Mode stays 2'b10; then ValidCmd=1 -> Busy stays 0.
REQ-042 Read: ValidCmd=1, RW=1 -> next cycle Busy=1, AccessMem=1, RWMem=1; then TransferData=1 until TransferDone; READY the cycle after, Busy=0.
REQ-043 Write: RW=0 -> SampleData=1; TransferDone on the 5th cycle -> following cycle AccessMem=1, RWMem=0 for exactly 1 cycle, then Busy=0.
REQ-044 TIMEOUT_CYCLES=4, write, no TransferDone -> Timeout pulses once, AccessMem never asserts, READY next.
REQ-045 Reset=0 asynchronously during RD_XFER -> all outputs 0 before the next edge; after release, ValidCmd is ignored until a new key loads.

Source files
------------

// File: rtl/multi_mode_controller_if.sv
// rtl/multi_mode_controller_if.sv - key/command/transceiver bundle for multi_mode_controller
//
// Purpose: groups every non-clock, non-reset signal of multi_mode_controller.
// The master modport drives the command side; the slave modport is the controller.
//
// Ports (direction seen from the slave):
//   KeyLoad      in   qualifies InputKey as a key bit
//   InputKey     in   serial key bit, MSB first
//   ValidCmd     in   command strobe
//   RW           in   command type: 1 = read, 0 = write
//   TransferDone in   transceiver completion
//   Busy         out  a command is in progress
//   Active       out  a valid key is loaded
//   Mode         out  mode field of the last valid key
//   AccessMem    out  memory access strobe
//   RWMem        out  memory direction: 1 = read, 0 = write
//   SampleData   out  transceiver sample enable
//   TransferData out  transceiver send enable
//   Timeout      out  one-cycle pulse on transfer timeout
//   KeyError     out  one-cycle pulse on key mismatch
interface multi_mode_controller_if #(
  parameter int MODE_WIDTH = 2
);
  logic                  KeyLoad;
  logic                  InputKey;
  logic                  ValidCmd;
  logic                  RW;
  logic                  TransferDone;
  logic                  Busy;
  logic                  Active;
  logic [MODE_WIDTH-1:0] Mode;
  logic                  AccessMem;
  logic                  RWMem;
  logic                  SampleData;
  logic                  TransferData;
  logic                  Timeout;
  logic                  KeyError;

  modport master (
    output KeyLoad, InputKey, ValidCmd, RW, TransferDone,
    input  Busy, Active, Mode, AccessMem, RWMem, SampleData, TransferData, Timeout, KeyError
  );

  modport slave (
    input  KeyLoad, InputKey, ValidCmd, RW, TransferDone,
    output Busy, Active, Mode, AccessMem, RWMem, SampleData, TransferData, Timeout, KeyError
  );
endinterface

// File: rtl/multi_mode_controller.sv
// rtl/multi_mode_controller.sv - serial-key gated read/write command controller
//
// Purpose: a serial key (MSB first) unlocks the controller and selects a mode.
// While unlocked, read commands do a one-cycle memory read followed by a
// transceiver send; write commands sample from the transceiver followed by a
// one-cycle memory write. Transceiver waits are bounded by TIMEOUT_CYCLES.
//
// Ports:
//   Clk    in  single clock, rising edge
//   Reset  in  asynchronous active-low reset
//   bus    slave modport of multi_mode_controller_if (key, command,
//          transceiver inputs; all outputs registered)
module multi_mode_controller #(
  parameter int KEY_WIDTH      = 8,
  parameter int MODE_WIDTH     = 2,
  parameter logic [KEY_WIDTH-MODE_WIDTH-1:0] KEY_ID = 6'h2B,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                    Clk,
  input logic                    Reset,
  multi_mode_controller_if.slave bus
);

  localparam int BW = $clog2(KEY_WIDTH + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(KEY_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  typedef enum logic [2:0] {
    IDLE, READY, RD_MEM, RD_XFER, WR_SAMPLE, WR_MEM
  } state_t;

  state_t                state;
  // Only KEY_WIDTH-1 bits need storing: the last bit is taken live from InputKey.
  logic [KEY_WIDTH-2:0]  shreg;
  logic [BW-1:0]         bcnt;
  logic [WW-1:0]         wcnt;

  logic                  busy;
  logic                  active;
  logic [MODE_WIDTH-1:0] mode;
  logic                  access_mem;
  logic                  rw_mem;
  logic                  sample_data;
  logic                  transfer_data;
  logic                  timeout;
  logic                  key_error;

  logic [KEY_WIDTH-1:0]  key_next;
  logic                  key_last;
  logic                  key_match;
  logic                  wait_expired;

  assign key_next     = {shreg, bus.InputKey};
  assign key_last     = bus.KeyLoad && !busy && (bcnt == BIT_LAST);
  assign key_match    = (key_next[KEY_WIDTH-1:MODE_WIDTH] == KEY_ID);
  // The edge where the count would reach TIMEOUT_CYCLES; TransferDone is tested first.
  assign wait_expired = (wcnt == WAIT_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bcnt          <= '0;
      wcnt          <= '0;
      busy          <= 1'b0;
      active        <= 1'b0;
      mode          <= '0;
      access_mem    <= 1'b0;
      rw_mem        <= 1'b0;
      sample_data   <= 1'b0;
      transfer_data <= 1'b0;
      timeout       <= 1'b0;
      key_error     <= 1'b0;
    end else begin
      key_error <= 1'b0;
      timeout   <= 1'b0;

      // Key shifter. Busy or a KeyLoad gap discards any partial key.
      if (busy || !bus.KeyLoad) begin
        bcnt <= '0;
      end else begin
        shreg <= key_next[KEY_WIDTH-2:0];
        if (bcnt == BIT_LAST) begin
          bcnt <= '0;
          if (key_match) begin
            active <= 1'b1;
            mode   <= key_next[MODE_WIDTH-1:0];
          end else begin
            active    <= 1'b0;
            key_error <= 1'b1;
          end
        end else begin
          bcnt <= bcnt + BIT_ONE;
        end
      end

      case (state)
        IDLE, READY: begin
          // A completing key takes priority over a command in the same cycle,
          // so the state always tracks the new Active value.
          if (key_last) begin
            state <= key_match ? READY : IDLE;
          end else if (state == READY && bus.ValidCmd) begin
            busy <= 1'b1;
            bcnt <= '0;
            if (bus.RW) begin
              state      <= RD_MEM;
              access_mem <= 1'b1;
              rw_mem     <= 1'b1;
            end else begin
              state       <= WR_SAMPLE;
              sample_data <= 1'b1;
              wcnt        <= '0;
            end
          end
        end

        RD_MEM: begin
          state         <= RD_XFER;
          access_mem    <= 1'b0;
          rw_mem        <= 1'b0;
          transfer_data <= 1'b1;
          wcnt          <= '0;
        end

        RD_XFER: begin
          wcnt <= wcnt + WAIT_ONE;
          if (bus.TransferDone || wait_expired) begin
            state         <= READY;
            transfer_data <= 1'b0;
            busy          <= 1'b0;
            timeout       <= !bus.TransferDone;
          end
        end

        WR_SAMPLE: begin
          wcnt <= wcnt + WAIT_ONE;
          if (bus.TransferDone) begin
            state       <= WR_MEM;
            sample_data <= 1'b0;
            access_mem  <= 1'b1;
            rw_mem      <= 1'b0;
          end else if (wait_expired) begin
            // Timed-out write never reaches memory.
            state       <= READY;
            sample_data <= 1'b0;
            busy        <= 1'b0;
            timeout     <= 1'b1;
          end
        end

        WR_MEM: begin
          state      <= READY;
          access_mem <= 1'b0;
          busy       <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          active        <= 1'b0;
          access_mem    <= 1'b0;
          rw_mem        <= 1'b0;
          sample_data   <= 1'b0;
          transfer_data <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy         = busy;
  assign bus.Active       = active;
  assign bus.Mode         = mode;
  assign bus.AccessMem    = access_mem;
  assign bus.RWMem        = rw_mem;
  assign bus.SampleData   = sample_data;
  assign bus.TransferData = transfer_data;
  assign bus.Timeout      = timeout;
  assign bus.KeyError     = key_error;

endmodule

// File: tb/tb_multi_mode_controller.sv
// tb/tb_multi_mode_controller.sv - directed self-checking bench for multi_mode_controller
module tb_multi_mode_controller;

  logic Clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  always #5 Clk = ~Clk;

  multi_mode_controller_if #(.MODE_WIDTH(2)) bus_a ();
  multi_mode_controller_if #(.MODE_WIDTH(2)) bus_b ();

  // dut_b sees the same stimulus but times out after 4 wait cycles.
  assign bus_b.KeyLoad      = bus_a.KeyLoad;
  assign bus_b.InputKey     = bus_a.InputKey;
  assign bus_b.ValidCmd     = bus_a.ValidCmd;
  assign bus_b.RW           = bus_a.RW;
  assign bus_b.TransferDone = bus_a.TransferDone;

  multi_mode_controller dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_a)
  );

  multi_mode_controller #(.TIMEOUT_CYCLES(4)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_b)
  );

  // Packed view: {Busy, Active, AccessMem, RWMem, SampleData, TransferData, Timeout, KeyError, Mode[1:0]}
  localparam logic [9:0] O_ZERO      = 10'b0000000000;
  localparam logic [9:0] O_IDLE_M2   = 10'b0000000010;
  localparam logic [9:0] O_KEYERR    = 10'b0000000110;
  localparam logic [9:0] O_READY     = 10'b0100000010;
  localparam logic [9:0] O_TIMEOUT   = 10'b0100001010;
  localparam logic [9:0] O_RD_MEM    = 10'b1111000010;
  localparam logic [9:0] O_RD_XFER   = 10'b1100010010;
  localparam logic [9:0] O_WR_SAMPLE = 10'b1100100010;
  localparam logic [9:0] O_WR_MEM    = 10'b1110000010;

  function automatic logic [9:0] outs_a();
    return {bus_a.Busy, bus_a.Active, bus_a.AccessMem, bus_a.RWMem, bus_a.SampleData,
            bus_a.TransferData, bus_a.Timeout, bus_a.KeyError, bus_a.Mode};
  endfunction

  function automatic logic [9:0] outs_b();
    return {bus_b.Busy, bus_b.Active, bus_b.AccessMem, bus_b.RWMem, bus_b.SampleData,
            bus_b.TransferData, bus_b.Timeout, bus_b.KeyError, bus_b.Mode};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] key);
    for (int i = 7; i >= 0; i--) begin
      bus_a.KeyLoad  = 1'b1;
      bus_a.InputKey = key[i];
      tick();
    end
    bus_a.KeyLoad  = 1'b0;
    bus_a.InputKey = 1'b0;
  endtask

  task automatic test_reset();
    Reset              = 1'b0;
    bus_a.KeyLoad      = 1'b0;
    bus_a.InputKey     = 1'b0;
    bus_a.ValidCmd     = 1'b0;
    bus_a.RW           = 1'b0;
    bus_a.TransferDone = 1'b0;
    tick();
    tests++; if (outs_a() !== O_ZERO) begin fails++; $display("FAIL reset_a: got %b expected %b", outs_a(), O_ZERO); end
    tests++; if (outs_b() !== O_ZERO) begin fails++; $display("FAIL reset_b: got %b expected %b", outs_b(), O_ZERO); end
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_key_match();
    logic [7:0] partial;
    partial = 8'b10101110;
    // Three bits, then a gap: the counter must restart from zero.
    for (int i = 7; i >= 5; i--) begin
      bus_a.KeyLoad  = 1'b1;
      bus_a.InputKey = partial[i];
      tick();
    end
    bus_a.KeyLoad = 1'b0;
    tick();
    tests++; if (outs_a() !== O_ZERO) begin fails++; $display("FAIL key_partial: got %b expected %b", outs_a(), O_ZERO); end
    load_key(8'b10101110);
    tests++; if (outs_a() !== O_READY) begin fails++; $display("FAIL key_match: got %b expected %b", outs_a(), O_READY); end
  endtask

  task automatic test_key_mismatch();
    load_key(8'b11111101);
    tests++; if (outs_a() !== O_KEYERR) begin fails++; $display("FAIL key_mismatch: got %b expected %b", outs_a(), O_KEYERR); end
    tick();
    tests++; if (outs_a() !== O_IDLE_M2) begin fails++; $display("FAIL key_error_pulse: got %b expected %b", outs_a(), O_IDLE_M2); end
    bus_a.ValidCmd = 1'b1;
    bus_a.RW       = 1'b1;
    tick();
    bus_a.ValidCmd = 1'b0;
    bus_a.RW       = 1'b0;
    tests++; if (outs_a() !== O_IDLE_M2) begin fails++; $display("FAIL cmd_inactive: got %b expected %b", outs_a(), O_IDLE_M2); end
    tick();
    tests++; if (outs_a() !== O_IDLE_M2) begin fails++; $display("FAIL cmd_inactive_2: got %b expected %b", outs_a(), O_IDLE_M2); end
    load_key(8'b10101110);
    tests++; if (outs_a() !== O_READY) begin fails++; $display("FAIL key_reload: got %b expected %b", outs_a(), O_READY); end
  endtask

  task automatic test_read();
    bus_a.ValidCmd = 1'b1;
    bus_a.RW       = 1'b1;
    tick();
    bus_a.ValidCmd = 1'b0;
    bus_a.RW       = 1'b0;
    tests++; if (outs_a() !== O_RD_MEM) begin fails++; $display("FAIL read_mem: got %b expected %b", outs_a(), O_RD_MEM); end
    tick();
    tests++; if (outs_a() !== O_RD_XFER) begin fails++; $display("FAIL read_xfer: got %b expected %b", outs_a(), O_RD_XFER); end
    // Key bits while busy must be ignored: ten ones would otherwise complete a bad key.
    bus_a.KeyLoad  = 1'b1;
    bus_a.InputKey = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests++; if (outs_a() !== O_RD_XFER) begin fails++; $display("FAIL read_hold_%0d: got %b expected %b", c, outs_a(), O_RD_XFER); end
    end
    bus_a.KeyLoad      = 1'b0;
    bus_a.InputKey     = 1'b0;
    bus_a.TransferDone = 1'b1;
    tick();
    bus_a.TransferDone = 1'b0;
    tests++; if (outs_a() !== O_READY) begin fails++; $display("FAIL read_done: got %b expected %b", outs_a(), O_READY); end
    tick();
    tests++; if (outs_a() !== O_READY) begin fails++; $display("FAIL read_idle: got %b expected %b", outs_a(), O_READY); end
  endtask

  task automatic test_write();
    bus_a.ValidCmd = 1'b1;
    bus_a.RW       = 1'b0;
    tick();
    bus_a.ValidCmd = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tests++; if (outs_a() !== O_WR_SAMPLE) begin fails++; $display("FAIL write_sample_%0d: got %b expected %b", c, outs_a(), O_WR_SAMPLE); end
      if (c == 5) bus_a.TransferDone = 1'b1;
      tick();
    end
    bus_a.TransferDone = 1'b0;
    tests++; if (outs_a() !== O_WR_MEM) begin fails++; $display("FAIL write_mem: got %b expected %b", outs_a(), O_WR_MEM); end
    tick();
    tests++; if (outs_a() !== O_READY) begin fails++; $display("FAIL write_done: got %b expected %b", outs_a(), O_READY); end
  endtask

  task automatic test_timeout();
    load_key(8'b10101110);
    tests++; if (outs_b() !== O_READY) begin fails++; $display("FAIL timeout_key: got %b expected %b", outs_b(), O_READY); end
    bus_a.ValidCmd = 1'b1;
    bus_a.RW       = 1'b0;
    tick();
    bus_a.ValidCmd = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tests++; if (outs_b() !== O_WR_SAMPLE) begin fails++; $display("FAIL timeout_wait_%0d: got %b expected %b", c, outs_b(), O_WR_SAMPLE); end
      tick();
    end
    tests++; if (outs_b() !== O_TIMEOUT) begin fails++; $display("FAIL timeout_pulse: got %b expected %b", outs_b(), O_TIMEOUT); end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if (outs_b() !== O_READY) begin fails++; $display("FAIL timeout_after_%0d: got %b expected %b", c, outs_b(), O_READY); end
    end
    // dut_a is still sampling; finish it. dut_b must ignore this TransferDone.
    bus_a.TransferDone = 1'b1;
    tick();
    bus_a.TransferDone = 1'b0;
    tests++; if (outs_b() !== O_READY) begin fails++; $display("FAIL done_ignored: got %b expected %b", outs_b(), O_READY); end
    tests++; if (outs_a() !== O_WR_MEM) begin fails++; $display("FAIL long_write_mem: got %b expected %b", outs_a(), O_WR_MEM); end
    tick();
  endtask

  task automatic test_timeout_tie();
    bus_a.ValidCmd = 1'b1;
    bus_a.RW       = 1'b0;
    tick();
    bus_a.ValidCmd = 1'b0;
    repeat (3) tick();
    // Fourth wait cycle: the count reaches its limit together with TransferDone.
    bus_a.TransferDone = 1'b1;
    tick();
    bus_a.TransferDone = 1'b0;
    tests++; if (outs_b() !== O_WR_MEM) begin fails++; $display("FAIL tie_b: got %b expected %b", outs_b(), O_WR_MEM); end
    tests++; if (outs_a() !== O_WR_MEM) begin fails++; $display("FAIL tie_a: got %b expected %b", outs_a(), O_WR_MEM); end
    tick();
    tests++; if (outs_b() !== O_READY) begin fails++; $display("FAIL tie_ready: got %b expected %b", outs_b(), O_READY); end
  endtask

  task automatic test_reset_async();
    logic [7:0] key;
    logic [9:0] exp;
    bus_a.ValidCmd = 1'b1;
    bus_a.RW       = 1'b1;
    tick();
    bus_a.ValidCmd = 1'b0;
    bus_a.RW       = 1'b0;
    tick();
    tests++; if (outs_a() !== O_RD_XFER) begin fails++; $display("FAIL pre_reset_xfer: got %b expected %b", outs_a(), O_RD_XFER); end
    #3;
    Reset = 1'b0;
    #1;
    tests++; if (outs_a() !== O_ZERO) begin fails++; $display("FAIL async_reset: got %b expected %b", outs_a(), O_ZERO); end
    tick();
    tests++; if (outs_a() !== O_ZERO) begin fails++; $display("FAIL reset_hold: got %b expected %b", outs_a(), O_ZERO); end
    // Release and begin a key load at once; a command is held throughout and must be ignored.
    Reset          = 1'b1;
    bus_a.ValidCmd = 1'b1;
    bus_a.RW       = 1'b1;
    key            = 8'b10101110;
    for (int i = 7; i >= 0; i--) begin
      bus_a.KeyLoad  = 1'b1;
      bus_a.InputKey = key[i];
      tick();
      exp = (i == 0) ? O_READY : O_ZERO;
      tests++; if (outs_a() !== exp) begin fails++; $display("FAIL post_reset_bit_%0d: got %b expected %b", i, outs_a(), exp); end
    end
    bus_a.KeyLoad  = 1'b0;
    bus_a.InputKey = 1'b0;
    bus_a.ValidCmd = 1'b0;
    bus_a.RW       = 1'b0;
    tick();
    tests++; if (outs_a() !== O_READY) begin fails++; $display("FAIL post_reset_ready: got %b expected %b", outs_a(), O_READY); end
  endtask

  initial begin
    test_reset();
    test_key_match();
    test_key_mismatch();
    test_read();
    test_write();
    test_timeout();
    test_timeout_tie();
    test_reset_async();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
